// File: rtl/check_zero_pkg.sv
// check_zero_pkg: shared constants and elaboration helpers for the zero-detect tree.
//   FANIN         inputs per reduction node (fixed at 4)
//   DEFAULT_WIDTH default data bus width
//   node_mode_e   node flavour: NOR (leaf groups) or AND (upper levels)
//   clog4         tree depth for a given bus width
//   nodes_at      node count on a given tree level
//   level_offset  first index of a level inside the flattened node vector
package check_zero_pkg;

  localparam int unsigned FANIN         = 4;
  localparam int unsigned DEFAULT_WIDTH = 64;

  typedef enum logic {
    NODE_NOR,
    NODE_AND
  } node_mode_e;

  // Never below 1: the leaf NOR level exists even for WIDTH <= 4.
  function automatic int unsigned clog4(input int unsigned width);
    int unsigned n;
    int unsigned d;
    n = (width + FANIN - 1) / FANIN;
    d = 1;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      d++;
    end
    return d;
  endfunction

  function automatic int unsigned nodes_at(input int unsigned width, input int unsigned level);
    int unsigned n;
    n = (width + FANIN - 1) / FANIN;
    for (int unsigned i = 0; i < level; i++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  function automatic int unsigned level_offset(input int unsigned width, input int unsigned level);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < level; i++) off += nodes_at(width, i);
    return off;
  endfunction

endpackage

// File: rtl/check_zero_reduce_node.sv
// zero_reduce_node: one 4-input node of the zero-detect reduction tree.
//   MODE = NODE_NOR : dout = 1 when all four data bits are 0 (leaf group)
//   MODE = NODE_AND : dout = 1 when all four children report zero
// Ports:
//   din   in  FANIN  node inputs
//   dout  out 1      node result
module zero_reduce_node
  import check_zero_pkg::*;
#(
  parameter node_mode_e MODE = NODE_AND
) (
  input  logic [FANIN-1:0] din,
  output logic             dout
);

  always_comb begin
    if (MODE == NODE_NOR) dout = ~|din;
    else                  dout = &din;
  end

endmodule

// File: rtl/check_zero.sv
// check_zero: registered zero-detect for the ALU result bus.
// zero = 1 iff every bit of the captured data is 0, computed by a balanced
// fan-in-4 tree (NOR leaves, AND upper levels).
// Ports:
//   clk        in   1      clock, all state on posedge
//   reset      in   1      synchronous active-high reset (zero<=1, out_valid<=0)
//   in_valid   in   1      capture qualifier for data
//   data       in   WIDTH  value to test
//   zero       out  1      registered zero flag; holds across idle cycles
//   out_valid  out  1      registered: zero belongs to a captured in_valid beat
// Build option:
//   CHECK_ZERO_PIPE_EN  adds a register stage after the leaf level (latency 2);
//                       undefined gives latency 1.
module check_zero
  import check_zero_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             out_valid
);

  localparam int unsigned LEVELS = clog4(WIDTH);
  localparam int unsigned N0     = nodes_at(WIDTH, 0);
  localparam int unsigned TOTAL  = level_offset(WIDTH, LEVELS);
  localparam int unsigned PADW   = N0 * FANIN;

  logic [PADW-1:0]  leaf_in;
  logic [N0-1:0]    grp_zero;
  logic [N0-1:0]    grp_sel;
  logic             stage_valid;
  // All tree levels flattened; level l starts at level_offset(WIDTH, l), root is last.
  logic [TOTAL-1:0] node;

  // Missing leaf inputs are 0 so they never spoil a group's NOR.
  if (PADW == WIDTH) begin : g_nopad
    assign leaf_in = data;
  end else begin : g_pad
    assign leaf_in = {{(PADW - WIDTH){1'b0}}, data};
  end

  for (genvar n = 0; n < N0; n++) begin : g_leaf
    zero_reduce_node #(.MODE(NODE_NOR)) u_node (
      .din  (leaf_in[n*FANIN +: FANIN]),
      .dout (grp_zero[n])
    );
  end

`ifdef CHECK_ZERO_PIPE_EN
  logic [N0-1:0] grp_q;
  logic          valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grp_q   <= '1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) grp_q <= grp_zero;
    end
  end

  assign grp_sel     = grp_q;
  assign stage_valid = valid_q;
`else
  assign grp_sel     = grp_zero;
  assign stage_valid = in_valid;
`endif

  assign node[N0-1:0] = grp_sel;

  for (genvar l = 1; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned CNT  = nodes_at(WIDTH, l);
    localparam int unsigned PCNT = nodes_at(WIDTH, l - 1);
    localparam int unsigned OFF  = level_offset(WIDTH, l);
    localparam int unsigned POFF = level_offset(WIDTH, l - 1);
    for (genvar n = 0; n < CNT; n++) begin : g_node
      logic [FANIN-1:0] kids;
      // Absent children read as "zero" (1) so the AND is unaffected.
      for (genvar j = 0; j < FANIN; j++) begin : g_kid
        if (n * FANIN + j < PCNT) begin : g_real
          assign kids[j] = node[POFF + n*FANIN + j];
        end else begin : g_tie
          assign kids[j] = 1'b1;
        end
      end
      zero_reduce_node #(.MODE(NODE_AND)) u_node (
        .din  (kids),
        .dout (node[OFF + n])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= stage_valid;
      if (stage_valid) zero <= node[TOTAL-1];
    end
  end

endmodule

// File: tb/tb_check_zero.sv
// tb_check_zero: scoreboard bench for check_zero at WIDTH=64 and WIDTH=6.
// Both instances share clock, reset and in_valid; the 6-bit one sees data[5:0].
module tb_check_zero;

`ifdef CHECK_ZERO_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] data;
  logic        zero64, ov64, zero6, ov6;

  always #5 clk = ~clk;

  check_zero #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .data      (data),
    .zero      (zero64),
    .out_valid (ov64)
  );

  check_zero #(.WIDTH(6)) dut6 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .data      (data[5:0]),
    .zero      (zero6),
    .out_valid (ov6)
  );

  typedef struct {
    logic        z64;
    logic        z6;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc   = 0;
  logic        rst_q = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic        hold64 = 1'b1;
  logic        hold6  = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs sampled mid-cycle, compared against the queued model.
  always @(negedge clk) begin
    logic exp_v;
    exp_t e;
    exp_v = 1'b0;
    if (cyc >= 1) begin
      if (rst_q) begin
        // Beats still inside the pipe at the reset edge are lost.
        while (q.size() > 0 && q[0].due < cyc + LAT) void'(q.pop_front());
        hold64 = 1'b1;
        hold6  = 1'b1;
      end else if (q.size() > 0 && q[0].due == cyc) begin
        e      = q.pop_front();
        hold64 = e.z64;
        hold6  = e.z6;
        exp_v  = 1'b1;
      end
      check("zero_w64",  zero64, hold64);
      check("valid_w64", ov64,   exp_v);
      check("zero_w6",   zero6,  hold6);
      check("valid_w6",  ov6,    exp_v);
    end
  end

  // Called just after a posedge; applies inputs for the next edge.
  task automatic drive(input logic r, input logic v, input logic [63:0] d);
    exp_t e;
    reset    = r;
    in_valid = v;
    data     = d;
    if (!r && v) begin
      e.z64 = (d == 64'd0);
      e.z6  = (d[5:0] == 6'd0);
      e.due = cyc + LAT;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] one;
    logic [63:0] d;
    logic        v;
    logic        r;
    one      = 64'h1;
    reset    = 1'b1;
    in_valid = 1'b0;
    data     = '0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 64'h0);

    drive(1'b0, 1'b1, 64'h0);
    for (int k = 0; k < 64; k++) drive(1'b0, 1'b1, one << k);

    drive(1'b0, 1'b1, 64'h8000_0000_0000_0000);
    drive(1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 64'h0);

    drive(1'b0, 1'b1, 64'h0);
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b0, 1'b1, 64'h0);

    drive(1'b0, 1'b1, 64'h20);
    drive(1'b0, 1'b1, 64'h0);
    drive(1'b0, 1'b1, 64'h5);
    drive(1'b1, 1'b1, 64'h5);
    drive(1'b0, 1'b0, 64'h0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = one << $urandom_range(0, 63);
        2:       d = {$urandom, $urandom};
        default: d = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFC0;
      endcase
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 49) == 0);
      drive(r, v, d);
    end

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 64'h0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats never presented, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
